dma_copy_master: RTL and testbench
==================================

# dma_copy_master

Memory-to-memory copy initiator for the DCNN I/O path. It accepts a copy command: source address, destination address and length in words. It moves data in bursts by driving the read/write request interface of the on-chip data memory, which is the responder side of the same protocol. Words are staged in a small local burst buffer between the read phase and the write phase. A one-cycle completion pulse is raised when the whole transfer has been written.

## Interface
- `ADDR_W`, 16: memory address width.
- `DATA_W`, 16: memory data width.
- `BURST`, 4: burst buffer depth in words; power of two, ≥1.

- `clk` in 1: clock; all logic on rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_src` in ADDR_W: first source address.
- `cmd_dst` in ADDR_W: first destination address.
- `cmd_len` in 16: word count; 0 is legal.
- `mem_addr` out ADDR_W: request address.
- `mem_wdata` out DATA_W: write data.
- `mem_rd` out 1: read request, held until `mem_done_rd`.
- `mem_wr` out 1: write request, held until `mem_done_wr`.
- `mem_rdata` in DATA_W: read data; valid in the cycle `mem_done_rd` is high.
- `mem_done_rd` in 1: read-complete pulse.
- `mem_done_wr` in 1: write-complete pulse.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle pulse at transfer end.
- `checksum` out DATA_W: only with `DMA_CHECKSUM_EN`.

## Operation
- States: IDLE, RD, RD_GAP, WR, WR_GAP, FIN.
- **IDLE**
  - `cmd_ready`=1.
  - On accept: latch src_ptr, dst_ptr and remaining.
  - Next state is FIN if `cmd_len`=0, else RD.
- **Burst set-up:** on entering each burst, burst_n = min(BURST, remaining), and rd/wr buffer indices are cleared.
- **RD**
  - Drive `mem_rd`=1 and `mem_addr`=src_ptr.
  - On `mem_done_rd`: buf[idx] ← `mem_rdata`, src_ptr++, idx++, then go to RD_GAP.
- **RD_GAP**
  - `mem_rd`=0 for exactly one cycle.
  - Go to RD if idx<burst_n, else WR with idx cleared.
- **WR**
  - Drive `mem_wr`=1, `mem_addr`=dst_ptr, `mem_wdata`=buf[idx].
  - On `mem_done_wr`: dst_ptr++, idx++, remaining--, then go to WR_GAP.
- **WR_GAP**
  - `mem_wr`=0 for one cycle.
  - Go to WR if idx<burst_n.
  - Otherwise go to FIN if remaining=0, else start the next burst in RD.
- **FIN:** `done`=1 for one cycle, then IDLE.
- `mem_rd` and `mem_wr` are never high together.
- A done input is honoured only in the state that requests it. Stray or crossed dones are ignored, including both dones high in the same cycle.
- Addresses increment modulo 2^ADDR_W; 0xFFFF wraps to 0x0000.
- Copy semantics are burst-wise forward. If dst lies in (src, src+len), the result is defined only when dst−src ≥ BURST.
- `cmd_valid` while busy: `cmd_ready`=0 and the command is not consumed.

## Timing
- Reset values:
  - `cmd_ready`=1.
  - `busy`, `done`, `mem_rd` and `mem_wr` = 0.
  - `mem_addr`, `mem_wdata` and `checksum` = 0.
  - State is IDLE.
- Buffer contents are not reset.
- All outputs are registered.
- `busy`=1 from the cycle after accept through the FIN cycle inclusive.
- Request timing:
  - A request rises the cycle after the state is entered.
  - A done sampled high on an edge ends the request at that edge.
- With a responder that answers in the first request cycle, each word costs 2 cycles to read and 2 to write. len=N then completes in 4N+2 cycles from accept to `done`. len=0 gives `done` 2 cycles after accept.
- `RST` mid-transfer: next edge forces IDLE and all outputs to reset values. An outstanding request is dropped with no further memory access.

## Configuration
- `DMA_CHECKSUM_EN` defined:
  - `checksum` port present.
  - It holds the 16-bit wrapping sum of every word written in the current command.
  - Cleared on command accept; updated on each `mem_done_wr` accepted in WR.
  - Stable after `done`.
- Undefined: the port and the adder are absent; all other behaviour is identical.

## Structure
- Package `dma_pkg`:
  - State enum `dma_state_t`.
  - `ADDR_W`/`DATA_W` defaults.
  - Localparam for index width, $clog2(BURST) with a minimum of 1.
- Sub-module `dma_burst_buf`: BURST×DATA_W register file with a write port (we, widx, wdata) and an async read (ridx → rdata). No reset on storage.

## Test plan
- Single word: preload mem[0x0010]=0xBEEF; cmd src=0x0010, dst=0x0020, len=1. Expect mem[0x0020]=0xBEEF, `done` at accept+6, `checksum`=0xBEEF.
- Multi-burst: len=10 with BURST=4 (bursts of 4, 4, 2) and src data 1..10. Expect dst=1..10, exactly 10 `mem_rd` and 10 `mem_wr` pulses, `busy` low after `done`.
- Wrap and zero length:
  - src=0xFFFE, len=4: reads hit 0xFFFE, 0xFFFF, 0x0000, 0x0001.
  - len=0: `done` 2 cycles after accept, no `mem_rd`/`mem_wr`.
- Slow and stray dones:
  - Responder delays each done by 3 cycles: requests hold, data is correct.
  - `mem_done_wr` pulsed during RD: ignored, no pointer change.
- Reset mid-burst: assert `RST` while `mem_rd`=1 in word 3 of 8. Next edge: all outputs 0 and `cmd_ready`=1. A new command afterwards completes correctly.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and defaults for the DMA copy master slice.
package dma_pkg;

  localparam int unsigned DMA_ADDR_W = 16;
  localparam int unsigned DMA_DATA_W = 16;
  localparam int unsigned DMA_BURST  = 4;

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned DMA_IDX_W = idx_width(DMA_BURST);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_GAP,
    S_WR,
    S_WR_GAP,
    S_FIN
  } dma_state_t;

endpackage

// File: rtl/dma_copy_master_buf.sv
// Burst staging buffer: one synchronous write port, one asynchronous read port.
module dma_burst_buf
  import dma_pkg::*;
#(
  parameter int unsigned DATA_W = DMA_DATA_W,
  parameter int unsigned DEPTH  = DMA_BURST,
  parameter int unsigned IDX_W  = idx_width(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata
);

  // Sized to the full index range so a depth of 1 never indexes out of bounds.
  logic [DATA_W-1:0] mem_q [2**IDX_W];

  always_ff @(posedge clk) begin
    if (we) mem_q[widx] <= wdata;
  end

  assign rdata = mem_q[ridx];

endmodule

// File: rtl/dma_copy_master.sv
// Burst-wise memory-to-memory copy initiator driving a rd/wr request interface.
// Optional running checksum of written words: define DMA_CHECKSUM_EN.
module dma_copy_master
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_W = DMA_ADDR_W,
  parameter int unsigned DATA_W = DMA_DATA_W,
  parameter int unsigned BURST  = DMA_BURST
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [15:0]       cmd_len,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done_rd,
  input  logic              mem_done_wr,
  output logic              busy,
  output logic              done
`ifdef DMA_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int unsigned IDX_W = idx_width(BURST);
  localparam int unsigned CNT_W = IDX_W + 1;

  dma_state_t        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [15:0]       rem_q, rem_d;
  logic [CNT_W-1:0]  idx_q, idx_d, bn_q, bn_d;
  logic              accept, start_burst, buf_we;
  logic [DATA_W-1:0] buf_rdata;

  logic              cmd_ready_q, busy_q, done_q, rd_q, wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  assign accept = cmd_ready_q && cmd_valid;

  dma_burst_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (BURST),
    .IDX_W  (IDX_W)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .widx  (idx_q[IDX_W-1:0]),
    .wdata (mem_rdata),
    .ridx  (idx_d[IDX_W-1:0]),
    .rdata (buf_rdata)
  );

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    rem_d       = rem_q;
    idx_d       = idx_q;
    bn_d        = bn_q;
    buf_we      = 1'b0;
    start_burst = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          src_d = cmd_src;
          dst_d = cmd_dst;
          rem_d = cmd_len;
          if (cmd_len == '0) begin
            state_d = S_FIN;
          end else begin
            state_d     = S_RD;
            start_burst = 1'b1;
          end
        end
      end
      S_RD: begin
        if (mem_done_rd) begin
          buf_we  = 1'b1;
          src_d   = src_q + 1'b1;
          idx_d   = idx_q + 1'b1;
          state_d = S_RD_GAP;
        end
      end
      S_RD_GAP: begin
        if (idx_q < bn_q) begin
          state_d = S_RD;
        end else begin
          state_d = S_WR;
          idx_d   = '0;
        end
      end
      S_WR: begin
        if (mem_done_wr) begin
          dst_d   = dst_q + 1'b1;
          idx_d   = idx_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          state_d = S_WR_GAP;
        end
      end
      S_WR_GAP: begin
        if (idx_q < bn_q) begin
          state_d = S_WR;
        end else if (rem_q == '0) begin
          state_d = S_FIN;
        end else begin
          state_d     = S_RD;
          start_burst = 1'b1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (start_burst) begin
      idx_d = '0;
      bn_d  = (32'(rem_d) >= BURST) ? CNT_W'(BURST) : CNT_W'(rem_d);
    end
  end

  // Request outputs are registered from the next state so a request is
  // visible in the first cycle its state is occupied; done trails FIN by one.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q     <= S_IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      rem_q       <= '0;
      idx_q       <= '0;
      bn_q        <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      rem_q       <= rem_d;
      idx_q       <= idx_d;
      bn_q        <= bn_d;
      cmd_ready_q <= (state_d == S_IDLE);
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_q == S_FIN);
      rd_q        <= (state_d == S_RD);
      wr_q        <= (state_d == S_WR);
      if (state_d == S_RD)      addr_q <= src_d;
      else if (state_d == S_WR) addr_q <= dst_d;
      if (state_d == S_WR)      wdata_q <= buf_rdata;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_rd    = rd_q;
  assign mem_wr    = wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

`ifdef DMA_CHECKSUM_EN
  logic              wr_ack;
  logic [DATA_W-1:0] sum_q;

  assign wr_ack = (state_q == S_WR) && mem_done_wr;

  always_ff @(posedge clk) begin
    if (RST || accept) sum_q <= '0;
    else if (wr_ack)   sum_q <= sum_q + wdata_q;
  end

  assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_dma_copy_master.sv
// Self-checking bench for dma_copy_master: responder memory plus sequence model.
module tb_dma_copy_master;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned BURST = 4;

  logic clk = 1'b0;
  logic RST = 1'b1;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [15:0]   cmd_src = '0, cmd_dst = '0, cmd_len = '0;
  logic [15:0]   mem_addr, mem_wdata;
  logic [15:0]   mem_rdata = '0;
  logic          mem_rd, mem_wr;
  logic          mem_done_rd = 1'b0, mem_done_wr = 1'b0;
  logic          busy, done;
`ifdef DMA_CHECKSUM_EN
  logic [15:0]   checksum;
`endif

  dma_copy_master #(.ADDR_W(AW), .DATA_W(DW), .BURST(BURST)) dut (
    .clk         (clk),
    .RST         (RST),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_src     (cmd_src),
    .cmd_dst     (cmd_dst),
    .cmd_len     (cmd_len),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_rdata   (mem_rdata),
    .mem_done_rd (mem_done_rd),
    .mem_done_wr (mem_done_wr),
    .busy        (busy),
    .done        (done)
`ifdef DMA_CHECKSUM_EN
    ,
    .checksum    (checksum)
`endif
  );

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [0:65535];
  int  resp_delay = 0;
  bit  stray = 1'b0;
  bit  mon_en = 1'b0;

  typedef struct packed { logic [15:0] a; logic [15:0] d; } wr_t;
  logic [15:0] rd_exp[$];
  wr_t         wr_exp[$];
  logic [15:0] rd_log[$];
  int rd_pulses = 0, wr_pulses = 0, wr_commits = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Responder: answers after resp_delay extra cycles; stray mode sprays crossed dones.
  int rd_wait = 0, wr_wait = 0;
  always @(negedge clk) begin
    mem_done_rd = 1'b0;
    mem_done_wr = 1'b0;
    mem_rdata   = 16'($urandom);
    if (mem_rd) begin
      if (rd_wait >= resp_delay) begin
        mem_done_rd = 1'b1;
        mem_rdata   = mem[mem_addr];
        rd_wait     = 0;
      end else rd_wait++;
      if (stray) mem_done_wr = 1'b1;
    end else rd_wait = 0;
    if (mem_wr) begin
      if (wr_wait >= resp_delay) begin
        mem_done_wr = 1'b1;
        wr_wait     = 0;
      end else wr_wait++;
      if (stray) mem_done_rd = 1'b1;
    end else wr_wait = 0;
    if (stray && !mem_rd && !mem_wr) begin
      mem_done_rd = 1'b1;
      mem_done_wr = 1'b1;
    end
  end

  always @(posedge clk) begin
    if (!RST && mem_wr && mem_done_wr) begin
      mem[mem_addr] = mem_wdata;
      wr_commits++;
    end
  end

  // Compare process: every request must match the next expected access in order.
  logic        prev_rd = 1'b0, prev_wr = 1'b0;
  logic [15:0] prev_addr = '0, prev_wdata = '0;
  always @(negedge clk) begin
    wr_t e;
    if (mon_en) begin
      chk("rd_wr_exclusive", 32'(mem_rd & mem_wr), 32'd0);
      if (mem_rd && !prev_rd) begin
        rd_pulses++;
        rd_log.push_back(mem_addr);
        if (rd_exp.size() == 0) begin
          checks++; failures++;
          $display("FAIL rd_unexpected: got read at %0h expected none", mem_addr);
        end else chk("rd_addr", 32'(mem_addr), 32'(rd_exp.pop_front()));
      end else if (mem_rd) chk("rd_addr_hold", 32'(mem_addr), 32'(prev_addr));
      if (mem_wr && !prev_wr) begin
        wr_pulses++;
        if (wr_exp.size() == 0) begin
          checks++; failures++;
          $display("FAIL wr_unexpected: got write at %0h expected none", mem_addr);
        end else begin
          e = wr_exp.pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(e.a));
          chk("wr_data", 32'(mem_wdata), 32'(e.d));
        end
      end else if (mem_wr) begin
        chk("wr_addr_hold", 32'(mem_addr), 32'(prev_addr));
        chk("wr_data_hold", 32'(mem_wdata), 32'(prev_wdata));
      end
    end
    prev_rd    = mem_rd;
    prev_wr    = mem_wr;
    prev_addr  = mem_addr;
    prev_wdata = mem_wdata;
  end

  task automatic preload(input logic [15:0] src, input int len);
    for (int i = 0; i < len; i++) mem[src + 16'(i)] = 16'($urandom);
  endtask

  task automatic issue(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                       output logic [15:0] sum, output logic [15:0] data[$]);
    int n;
    logic [15:0] a;
    wr_t w;
    sum = '0;
    data.delete();
    rd_pulses = 0; wr_pulses = 0;
    rd_log.delete(); rd_exp.delete(); wr_exp.delete();
    for (int i = 0; i < int'(len); i++) begin
      a   = src + 16'(i);
      w.a = dst + 16'(i);
      w.d = mem[a];
      rd_exp.push_back(a);
      wr_exp.push_back(w);
      data.push_back(w.d);
      sum = sum + w.d;
    end
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_src = src; cmd_dst = dst; cmd_len = len; cmd_valid = 1'b1;
    @(negedge clk);
  endtask

  // lat counts cycles from the accept edge to the cycle showing done.
  task automatic run_cmd(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                         input int dly, input bit str, output int lat);
    logic [15:0] sum;
    logic [15:0] data[$];
    int exp_lat;
    resp_delay = dly;
    stray      = str;
    exp_lat    = 2 + 2 * int'(len) * (dly + 2);
    issue(src, dst, len, sum, data);
    lat = 1;
    while (!done && lat < 5000) begin
      chk("busy_during", 32'(busy), 32'd1);
      chk("ready_low_busy", 32'(cmd_ready), 32'd0);
      cmd_valid = str;
      if (str) begin cmd_src = 16'($urandom); cmd_len = 16'($urandom); end
      @(negedge clk);
      lat++;
    end
    cmd_valid = 1'b0;
    stray = 1'b0;
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("rd_count", 32'(rd_pulses), 32'(len));
    chk("wr_count", 32'(wr_pulses), 32'(len));
    chk("rd_left", 32'(rd_exp.size()), 32'd0);
    chk("wr_left", 32'(wr_exp.size()), 32'd0);
`ifdef DMA_CHECKSUM_EN
    chk("checksum", 32'(checksum), 32'(sum));
`endif
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
`ifdef DMA_CHECKSUM_EN
    chk("checksum_stable", 32'(checksum), 32'(sum));
`endif
    for (int i = 0; i < int'(len); i++)
      chk("dst_data", 32'(mem[dst + 16'(i)]), 32'(data[i]));
  endtask

  task automatic reset_mid();
    logic [15:0] sum;
    logic [15:0] data[$];
    int n, c0;
    preload(16'h3000, 8);
    resp_delay = 2;
    issue(16'h3000, 16'h3100, 16'd8, sum, data);
    cmd_valid = 1'b0;
    n = 0;
    while (!(mem_rd && rd_pulses == 3) && n < 500) begin @(negedge clk); n++; end
    chk("rst_reach_word3", 32'(rd_pulses), 32'd3);
    c0  = wr_commits;
    RST = 1'b1;
    @(negedge clk);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    RST = 1'b0;
    rd_exp.delete(); wr_exp.delete();
    repeat (5) begin
      @(negedge clk);
      chk("rst_no_request", 32'({mem_rd, mem_wr}), 32'd0);
    end
    chk("rst_no_writes", 32'(wr_commits), 32'(c0));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish within 50000 cycles");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    logic [15:0] s, d, l;
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(cmd_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_rd", 32'(mem_rd), 32'd0);
    chk("reset_wr", 32'(mem_wr), 32'd0);
    chk("reset_addr", 32'(mem_addr), 32'd0);
    chk("reset_wdata", 32'(mem_wdata), 32'd0);
`ifdef DMA_CHECKSUM_EN
    chk("reset_checksum", 32'(checksum), 32'd0);
`endif
    RST = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    mem[16'h0010] = 16'hBEEF;
    run_cmd(16'h0010, 16'h0020, 16'd1, 0, 1'b0, lat);
    chk("single_latency", 32'(lat), 32'd6);
    chk("single_data", 32'(mem[16'h0020]), 32'h0000BEEF);
`ifdef DMA_CHECKSUM_EN
    chk("single_checksum", 32'(checksum), 32'h0000BEEF);
`endif

    for (int i = 0; i < 10; i++) mem[16'h0100 + 16'(i)] = 16'(i + 1);
    run_cmd(16'h0100, 16'h0200, 16'd10, 0, 1'b0, lat);
    chk("multi_latency", 32'(lat), 32'd42);
    chk("multi_rd_pulses", 32'(rd_pulses), 32'd10);
    chk("multi_wr_pulses", 32'(wr_pulses), 32'd10);
    for (int i = 0; i < 10; i++) chk("multi_data", 32'(mem[16'h0200 + 16'(i)]), 32'(i + 1));

    preload(16'hFFFE, 4);
    run_cmd(16'hFFFE, 16'h0400, 16'd4, 0, 1'b0, lat);
    chk("wrap_log_size", 32'(rd_log.size()), 32'd4);
    if (rd_log.size() == 4) begin
      chk("wrap_rd0", 32'(rd_log[0]), 32'h0000FFFE);
      chk("wrap_rd1", 32'(rd_log[1]), 32'h0000FFFF);
      chk("wrap_rd2", 32'(rd_log[2]), 32'h00000000);
      chk("wrap_rd3", 32'(rd_log[3]), 32'h00000001);
    end

    run_cmd(16'h0500, 16'h0600, 16'd0, 0, 1'b0, lat);
    chk("zero_latency", 32'(lat), 32'd2);
    chk("zero_no_rd", 32'(rd_pulses), 32'd0);

    preload(16'h0700, 6);
    run_cmd(16'h0700, 16'h0800, 16'd6, 3, 1'b0, lat);
    chk("slow_latency", 32'(lat), 32'd62);

    preload(16'h0900, 5);
    run_cmd(16'h0900, 16'h0A00, 16'd5, 0, 1'b1, lat);

    reset_mid();
    preload(16'h3000, 8);
    run_cmd(16'h3000, 16'h3100, 16'd8, 0, 1'b0, lat);

    repeat (12) begin
      s = 16'($urandom);
      d = s + 16'h4000 + 16'($urandom_range(0, 16'h1000));
      l = 16'($urandom_range(0, 20));
      preload(s, int'(l));
      run_cmd(s, d, l, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
